// File: rtl/seven_seg_mux.sv
// seven_seg_mux: time-multiplexed common-anode 7-segment driver with dead time and per-frame double buffering
//   clk, reset (sync, active-low) | digits[4*NUM_DIGITS], digit_en[NUM_DIGITS] in
//   seg[7] active-low {g..a}, anode[NUM_DIGITS] one-hot per ANODE_ACTIVE_LOW, frame_done pulse out
module seven_seg_mux #(
  parameter int NUM_DIGITS       = 2,
  parameter int REFRESH_CYCLES   = 24000,
  parameter int DEADTIME_CYCLES  = 240,
  parameter int INVERT_IN        = 1,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);
  localparam int CW = $clog2((REFRESH_CYCLES > DEADTIME_CYCLES ? REFRESH_CYCLES : DEADTIME_CYCLES) + 1);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef enum logic {DEAD, SHOW} state_t;
  state_t                  state;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic [4*NUM_DIGITS-1:0] shadow_digits;
  logic [NUM_DIGITS-1:0]   shadow_en;
  logic [NUM_DIGITS-1:0]   one_hot;
  logic [3:0]              nib;
  logic                    last;
  logic                    on;
  assign last = state == SHOW ? cnt == CW'(REFRESH_CYCLES - 1) : cnt == CW'(DEADTIME_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= DEAD;
      idx           <= '0;
      cnt           <= '0;
      shadow_digits <= '0;
      shadow_en     <= '0;
      frame_done    <= 1'b0;
    end else begin
      // the first dead slot of digit 0 is the frame boundary: latch a whole frame's data at once
      if (state == DEAD && idx == '0 && cnt == '0) begin
        shadow_digits <= digits;
        shadow_en     <= digit_en;
      end
      frame_done <= state == SHOW && last && idx == IW'(NUM_DIGITS - 1);
      cnt        <= last ? '0 : cnt + 1'b1;
      if (last)
        state <= state == SHOW ? DEAD : SHOW;
      if (last && state == SHOW)
        idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
    end
  end
  always_comb begin
    nib     = shadow_digits[{idx, 2'b00} +: 4];
    on      = state == SHOW && shadow_en[idx];
    one_hot = on ? NUM_DIGITS'(1) << idx : '0;
    anode   = ANODE_ACTIVE_LOW != 0 ? ~one_hot : one_hot;
    seg     = on ? SEG_LUT[INVERT_IN != 0 ? ~nib : nib] : 7'h7F;
  end
endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: randomized and directed checks of seven_seg_mux against a frame-position model
module tb_seven_seg_mux;
  localparam int N = 4;
  localparam int R = 8;
  localparam int D = 2;
  localparam int F = N * (R + D);
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0] digit_en = '0;
  logic [6:0] seg;
  logic [3:0] anode;
  logic frame_done;
  logic reset2 = 1'b0;
  logic [7:0] digits2 = '0;
  logic [1:0] en2 = '0;
  logic [6:0] seg2;
  logic [1:0] anode2;
  logic fd2;
  int checks = 0;
  int failures = 0;
  int mt = 0;
  logic [15:0] msd = '0;
  logic [3:0] men = '0;
  logic [6:0] lut [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  always #5 clk = ~clk;
  seven_seg_mux #(.NUM_DIGITS(N), .REFRESH_CYCLES(R), .DEADTIME_CYCLES(D), .INVERT_IN(0), .ANODE_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .digits(digits), .digit_en(digit_en),
    .seg(seg), .anode(anode), .frame_done(frame_done)
  );
  seven_seg_mux #(.NUM_DIGITS(2), .REFRESH_CYCLES(R), .DEADTIME_CYCLES(D), .INVERT_IN(1), .ANODE_ACTIVE_LOW(1)) dut2 (
    .clk(clk), .reset(reset2), .digits(digits2), .digit_en(en2),
    .seg(seg2), .anode(anode2), .frame_done(fd2)
  );
  // model: mt = cycles since the last reset edge; a frame's data is taken at its first cycle
  always @(posedge clk) begin
    if (!reset) begin
      mt  <= 0;
      msd <= '0;
      men <= '0;
    end else begin
      if (mt % F == 0) begin
        msd <= digits;
        men <= digit_en;
      end
      mt <= mt + 1;
    end
  end
  function automatic logic [11:0] expv();
    int pos, s;
    logic on;
    pos = mt % F;
    s   = pos / (R + D);
    on  = (pos % (R + D) >= D) && men[s];
    return {on ? lut[msd[4*s +: 4]] : 7'h7F, on ? ~(4'b0001 << s) : 4'hF, pos == 0 && mt > 0};
  endfunction
  task automatic sync_to(input int p);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (mt % F != p && k < 2 * F);
    if (mt % F != p) begin
      checks++;
      failures++;
      $display("FAIL sync_to: position %0d required %0d", mt % F, p);
    end
  endtask
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg: got %h want 7f", seg); end
    checks++;
    if (anode !== 4'hF) begin failures++; $display("FAIL reset_anode: got %b want 1111", anode); end
    checks++;
    if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd: got %b want 0", frame_done); end
  endtask
  task automatic test_sequence();
    logic [10:0] slot_exp [4] = '{{4'b1110, 7'b1000000}, {4'b1101, 7'b1111001}, {4'b1011, 7'b0100100}, {4'b0111, 7'b0110000}};
    int last, pulses;
    last = -1;
    pulses = 0;
    digits = 16'h3210;
    digit_en = 4'hF;
    reset = 1'b1;
    for (int i = 1; i <= 3 * F; i++) begin
      @(negedge clk);
      checks++;
      if ({seg, anode, frame_done} !== expv()) begin
        failures++;
        $display("FAIL seq_model t=%0d: got %h want %h", i, {seg, anode, frame_done}, expv());
      end
      if (i == 1 || i == 10 || i == 11) begin
        checks++;
        if ({anode, seg} !== {4'hF, 7'h7F}) begin failures++; $display("FAIL seq_blank t=%0d: got %h", i, {anode, seg}); end
      end
      if (i < F && i % (R + D) == D) begin
        checks++;
        if ({anode, seg} !== slot_exp[i / (R + D)]) begin
          failures++;
          $display("FAIL seq_slot t=%0d: got %b want %b", i, {anode, seg}, slot_exp[i / (R + D)]);
        end
      end
      if (frame_done) begin
        pulses++;
        if (last >= 0) begin
          checks++;
          if (i - last != F) begin failures++; $display("FAIL fd_period: got %0d want %0d", i - last, F); end
        end
        last = i;
      end
    end
    checks++;
    if (pulses != 3) begin failures++; $display("FAIL fd_count: got %0d want 3", pulses); end
  endtask
  task automatic test_decode_sweep();
    for (int v = 0; v < 16; v++) begin
      sync_to(F - 1);
      digits[3:0] = 4'(v);
      for (int i = 0; i < R + D; i++) begin
        @(negedge clk);
        checks++;
        if ({seg, anode, frame_done} !== expv()) begin
          failures++;
          $display("FAIL sweep_model v=%0d: got %h want %h", v, {seg, anode, frame_done}, expv());
        end
        if (i == D) begin
          checks++;
          if (seg !== lut[v]) begin failures++; $display("FAIL sweep_seg v=%0d: got %b want %b", v, seg, lut[v]); end
        end
      end
    end
  endtask
  task automatic test_invert();
    digits2 = 8'hFE;
    en2 = 2'b11;
    reset2 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if (fd2 !== (i == 20)) begin failures++; $display("FAIL inv_fd t=%0d: got %b", i, fd2); end
      if (i == 1 || i == 10) begin
        checks++;
        if ({anode2, seg2} !== {2'b11, 7'h7F}) begin failures++; $display("FAIL inv_blank t=%0d: got %b", i, {anode2, seg2}); end
      end
      if (i == 2 || i == 9) begin
        checks++;
        if ({anode2, seg2} !== {2'b10, 7'b1111001}) begin failures++; $display("FAIL inv_d0 t=%0d: got %b want 101111001", i, {anode2, seg2}); end
      end
      if (i == 12 || i == 19) begin
        checks++;
        if ({anode2, seg2} !== {2'b01, 7'b1000000}) begin failures++; $display("FAIL inv_d1 t=%0d: got %b want 011000000", i, {anode2, seg2}); end
      end
    end
  endtask
  task automatic test_midframe_change();
    digits = 16'h3210;
    digit_en = 4'hF;
    sync_to(F - 1);
    sync_to(15);
    digits = 16'hABCD;
    for (int i = 16; i < 2 * F; i++) begin
      @(negedge clk);
      checks++;
      if ({seg, anode, frame_done} !== expv()) begin
        failures++;
        $display("FAIL mid_model t=%0d: got %h want %h", i, {seg, anode, frame_done}, expv());
      end
      if (i == 22 || i == 32 || i == F + 2 || i == F + 12) begin
        checks++;
        if (seg !== (i == 22 ? 7'b0100100 : i == 32 ? 7'b0110000 : i == F + 2 ? 7'b0100001 : 7'b1000110)) begin
          failures++;
          $display("FAIL mid_seg t=%0d: got %b", i, seg);
        end
      end
    end
  endtask
  task automatic test_blanking();
    digits = 16'h3210;
    digit_en = 4'b1010;
    sync_to(F - 1);
    for (int i = 0; i < 2 * F; i++) begin
      @(negedge clk);
      checks++;
      if ({seg, anode, frame_done} !== expv()) begin
        failures++;
        $display("FAIL blank_model t=%0d: got %h want %h", i, {seg, anode, frame_done}, expv());
      end
      checks++;
      if (frame_done !== (i % F == 0)) begin failures++; $display("FAIL blank_fd t=%0d: got %b", i, frame_done); end
      if (i >= F && (i % F == 2 || i % F == 22)) begin
        checks++;
        if ({anode, seg} !== {4'hF, 7'h7F}) begin failures++; $display("FAIL blank_slot t=%0d: got %b", i, {anode, seg}); end
      end
      if (i >= F && i % F == 12) begin
        checks++;
        if ({anode, seg} !== {4'b1101, 7'b1111001}) begin failures++; $display("FAIL blank_d1 t=%0d: got %b", i, {anode, seg}); end
      end
    end
  endtask
  task automatic test_reset_mid();
    digits = 16'h3210;
    digit_en = 4'hF;
    sync_to(25);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if ({seg, anode, frame_done} !== {7'h7F, 4'hF, 1'b0}) begin
      failures++;
      $display("FAIL rmid_blank: got %h want %h", {seg, anode, frame_done}, {7'h7F, 4'hF, 1'b0});
    end
    for (int i = 1; i <= 2 * F; i++) begin
      @(negedge clk);
      checks++;
      if ({seg, anode, frame_done} !== expv()) begin
        failures++;
        $display("FAIL rmid_model t=%0d: got %h want %h", i, {seg, anode, frame_done}, expv());
      end
      checks++;
      if (frame_done !== (i == F || i == 2 * F)) begin failures++; $display("FAIL rmid_fd t=%0d: got %b", i, frame_done); end
      if (i == 2) begin
        checks++;
        if ({anode, seg} !== {4'b1110, 7'b1000000}) begin failures++; $display("FAIL rmid_d0: got %b", {anode, seg}); end
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 12 * F; i++) begin
      @(negedge clk);
      checks++;
      if ({seg, anode, frame_done} !== expv()) begin
        failures++;
        $display("FAIL rand_model i=%0d: got %h want %h", i, {seg, anode, frame_done}, expv());
      end
      if ($urandom_range(9) == 0) begin
        digits = 16'($urandom);
        digit_en = 4'($urandom);
      end
    end
  endtask
  initial begin
    test_reset();
    test_sequence();
    test_decode_sweep();
    test_invert();
    test_midframe_change();
    test_blanking();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
